// File: rtl/game_rotate_ctrl.sv
// rtl/game_rotate_ctrl.sv - whole-board rotation sequencer for the game engine
module game_rotate_ctrl #(
  parameter int AUTO_PERIOD  = 6000,
  parameter int HOLD_TIMEOUT = 255,
  parameter int SETTLE       = 2,
  parameter int COOLDOWN     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rot_cw_req,
  input  logic       rot_ccw_req,
  input  logic       auto_en,
  input  logic       game_idle,
  input  logic       collide,
  output logic       hold,
  output logic       sel_cw,
  output logic       sel_ccw,
  output logic       commit,
  output logic       reject,
  output logic       busy,
  output logic [1:0] orientation,
  output logic       dims_swapped
);

  // Counter widths; every counter is at least one bit wide even for degenerate parameters
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam int WAIT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam int SETL_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(HOLD_TIMEOUT - 1);
  localparam logic [SETL_W-1:0] SETL_LAST = SETL_W'(SETTLE - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_REJECT = 3'd4,
    ST_COOL   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AUTO_W-1:0] auto_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [SETL_W-1:0] settle_cnt;
  logic [COOL_W-1:0] cool_cnt;
  logic              dir_ccw;

  logic ext_any;
  logic ext_cw;
  logic ext_ccw;
  logic auto_fire;
  logic accept;

  // A simultaneous CW+CCW press is a cancel; a lone press always beats the auto pulse
  assign ext_any   = rot_cw_req | rot_ccw_req;
  assign ext_cw    = rot_cw_req & ~rot_ccw_req;
  assign ext_ccw   = rot_ccw_req & ~rot_cw_req;
  assign auto_fire = (state == ST_IDLE) && auto_en && (auto_cnt == AUTO_LAST);
  assign accept    = (state == ST_IDLE) && (cool_cnt == '0) &&
                     (ext_cw || ext_ccw || (auto_fire && !ext_any));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (game_idle)                  state_nxt = ST_CHECK;
        else if (wait_cnt == WAIT_LAST) state_nxt = ST_REJECT;
      end
      ST_CHECK: begin
        if (!game_idle)                   state_nxt = ST_HOLD;
        else if (settle_cnt == SETL_LAST) state_nxt = collide ? ST_REJECT : ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_COOL;
      ST_REJECT: state_nxt = ST_COOL;
      ST_COOL: begin
        if (cool_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs, so an asynchronous reset clears them without waiting for a clock
  always_comb begin
    hold    = 1'b0;
    sel_cw  = 1'b0;
    sel_ccw = 1'b0;
    commit  = 1'b0;
    reject  = 1'b0;
    busy    = 1'b1;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_HOLD: hold = 1'b1;
      ST_CHECK: begin
        hold    = 1'b1;
        sel_cw  = ~dir_ccw;
        sel_ccw = dir_ccw;
      end
      ST_COMMIT: begin
        hold    = 1'b1;
        sel_cw  = ~dir_ccw;
        sel_ccw = dir_ccw;
        commit  = 1'b1;
      end
      ST_REJECT: begin
        hold   = 1'b1;
        reject = 1'b1;
      end
      ST_COOL: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Latch the direction of the accepted request for the whole rotation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_ccw <= 1'b0;
    end else if (accept) begin
      dir_ccw <= ext_ccw;
    end
  end

  // Auto-rotate timer: runs only while idle, restarts after every commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_cnt <= '0;
    end else if (!auto_en || state == ST_COMMIT) begin
      auto_cnt <= '0;
    end else if (state == ST_IDLE) begin
      auto_cnt <= (auto_cnt == AUTO_LAST) ? '0 : auto_cnt + AUTO_W'(1);
    end
  end

  // Wait-for-idle timeout; survives CHECK->HOLD bounces so a flickering engine still times out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else if (state == ST_HOLD && !game_idle) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Settle window: counts CHECK cycles, restarts on every entry into CHECK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (state == ST_CHECK) begin
      settle_cnt <= settle_cnt + SETL_W'(1);
    end else begin
      settle_cnt <= '0;
    end
  end

  // Cooldown: loaded on the commit/reject strobe, drained in COOL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cool_cnt <= '0;
    end else if (state == ST_COMMIT || state == ST_REJECT) begin
      cool_cnt <= COOL_LOAD;
    end else if (state == ST_COOL && cool_cnt != '0) begin
      cool_cnt <= cool_cnt - COOL_W'(1);
    end
  end

  // Committed quarter-turns, wrapping naturally in two bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orientation <= 2'd0;
    end else if (state == ST_COMMIT) begin
      orientation <= dir_ccw ? orientation - 2'd1 : orientation + 2'd1;
    end
  end

  assign dims_swapped = orientation[0];

endmodule

// File: tb/tb_game_rotate_ctrl.sv
// tb/tb_game_rotate_ctrl.sv - self-checking bench for game_rotate_ctrl
module tb_game_rotate_ctrl;
  localparam int AP = 10;
  localparam int HT = 8;
  localparam int ST = 2;
  localparam int CD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rot_cw_req, rot_ccw_req, auto_en, game_idle, collide;
  logic       hold, sel_cw, sel_ccw, commit, reject, busy, dims_swapped;
  logic [1:0] orientation;
  wire  [8:0] obs = {busy, hold, sel_cw, sel_ccw, commit, reject, dims_swapped, orientation};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_rotate_ctrl #(
    .AUTO_PERIOD (AP),
    .HOLD_TIMEOUT(HT),
    .SETTLE      (ST),
    .COOLDOWN    (CD)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .rot_cw_req  (rot_cw_req),
    .rot_ccw_req (rot_ccw_req),
    .auto_en     (auto_en),
    .game_idle   (game_idle),
    .collide     (collide),
    .hold        (hold),
    .sel_cw      (sel_cw),
    .sel_ccw     (sel_ccw),
    .commit      (commit),
    .reject      (reject),
    .busy        (busy),
    .orientation (orientation),
    .dims_swapped(dims_swapped)
  );

  typedef struct {
    logic       cw;
    logic       ccw;
    logic       gi;
    logic       col;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [8:0] mk(input logic b, input logic h, input logic sc,
                                    input logic scc, input logic c, input logic r,
                                    input logic [1:0] o);
    return {b, h, sc, scc, c, r, o[0], o};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got busy,hold,cw,ccw,commit,reject,dims,orient=%b required %b",
               name, obs, exp);
    end
  endtask

  task automatic drive(input logic cw, input logic ccw, input logic gi, input logic col);
    rot_cw_req  = cw;
    rot_ccw_req = ccw;
    game_idle   = gi;
    collide     = col;
  endtask

  task automatic addv(input logic cw, input logic ccw, input logic gi, input logic col,
                      input logic [8:0] exp);
    vec_t v;
    v.cw = cw; v.ccw = ccw; v.gi = gi; v.col = col; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rotate(input logic ccw, input logic [1:0] o_before, input logic [1:0] o_after);
    @(negedge clk);
    check("rot_idle", mk(0, 0, 0, 0, 0, 0, o_before));
    drive(!ccw, ccw, 1, 0);
    @(negedge clk);
    drive(0, 0, 1, 0);
    repeat (ST + 1) @(negedge clk);
    check("rot_commit_latency", mk(1, 1, !ccw, ccw, 1, 0, o_before));
    repeat (CD + 2) @(negedge clk);
    check("rot_orientation", mk(0, 0, 0, 0, 0, 0, o_after));
  endtask

  task automatic idle_run(output int n);
    int guard;
    guard = 0;
    n = 0;
    while (busy && guard < 60) begin @(negedge clk); guard++; end
    while (!busy && guard < 60) begin n++; @(negedge clk); guard++; end
    checks++;
    if (guard >= 60) begin
      errors++;
      $display("FAIL auto_wait: no auto request within %0d cycles, required one after %0d", guard, AP);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ori;
    int         n;
    logic [8:0] bounce_exp [1:12];
    logic       bounce_gi  [1:12];

    rst = 1'b1;
    auto_en = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset_state", mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // CW commit, cancel, CCW collide reject, request in cooldown
    addv(1, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0));
    addv(0, 0, 1, 0, mk(1, 1, 0, 0, 0, 0, 0));
    addv(0, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 0));
    addv(0, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 0));
    addv(0, 0, 1, 0, mk(1, 1, 1, 0, 1, 0, 0));
    for (int i = 0; i < CD + 1; i++) addv(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 1));
    addv(1, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 1));
    addv(0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 1));
    addv(0, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 1));
    addv(0, 0, 1, 1, mk(1, 1, 0, 0, 0, 0, 1));
    addv(0, 0, 1, 1, mk(1, 1, 0, 1, 0, 0, 1));
    addv(0, 0, 1, 1, mk(1, 1, 0, 1, 0, 0, 1));
    addv(0, 0, 1, 0, mk(1, 1, 0, 0, 0, 1, 1));
    addv(1, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < CD; i++) addv(0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 1));
    addv(0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("tbl[%0d]", i), tbl[i].exp);
      drive(tbl[i].cw, tbl[i].ccw, tbl[i].gi, tbl[i].col);
    end

    // Orientation walk with wraparound in both directions
    do_reset();
    rotate(0, 2'd0, 2'd1);
    rotate(0, 2'd1, 2'd2);
    rotate(0, 2'd2, 2'd3);
    rotate(0, 2'd3, 2'd0);
    rotate(1, 2'd0, 2'd3);
    ori = 2'd3;

    // HOLD timeout with game_idle stuck low
    @(negedge clk);
    drive(1, 0, 0, 0);
    for (int r = 1; r <= HT + 2; r++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      if (r <= HT)          check($sformatf("timeout_hold[%0d]", r), mk(1, 1, 0, 0, 0, 0, ori));
      else if (r == HT + 1) check("timeout_reject", mk(1, 1, 0, 0, 0, 1, ori));
      else                  check("timeout_release", mk(1, 0, 0, 0, 0, 0, ori));
    end
    repeat (CD + 1) @(negedge clk);
    check("timeout_idle", mk(0, 0, 0, 0, 0, 0, ori));

    // game_idle drops during CHECK; timeout keeps counting across the bounce
    for (int r = 1; r <= 12; r++) begin
      bounce_gi[r]  = (r == 6);
      bounce_exp[r] = mk(1, 1, 0, 0, 0, 0, ori);
    end
    bounce_exp[7]  = mk(1, 1, 1, 0, 0, 0, ori);
    bounce_exp[11] = mk(1, 1, 0, 0, 0, 1, ori);
    bounce_exp[12] = mk(1, 0, 0, 0, 0, 0, ori);
    @(negedge clk);
    drive(1, 0, 0, 0);
    for (int r = 1; r <= 12; r++) begin
      @(negedge clk);
      check($sformatf("bounce[%0d]", r), bounce_exp[r]);
      drive(0, 0, bounce_gi[r], 0);
    end
    repeat (CD + 1) @(negedge clk);
    check("bounce_idle", mk(0, 0, 0, 0, 0, 0, ori));

    // Auto requests every AP idle cycles; CCW in cooldown is dropped; reset in CHECK
    do_reset();
    ori = 2'd0;
    @(negedge clk);
    drive(0, 0, 1, 0);
    auto_en = 1'b1;
    for (int rnd = 0; rnd < 2; rnd++) begin
      idle_run(n);
      checks++;
      if (n != AP) begin
        errors++;
        $display("FAIL auto_period[%0d]: idle cycles %0d required %0d", rnd, n, AP);
      end
      check("auto_hold", mk(1, 1, 0, 0, 0, 0, ori));
      repeat (ST + 1) @(negedge clk);
      check("auto_commit", mk(1, 1, 1, 0, 1, 0, ori));
      ori = ori + 2'd1;
      @(negedge clk);
      check("auto_cool", mk(1, 0, 0, 0, 0, 0, ori));
      rot_ccw_req = 1'b1;
      @(negedge clk);
      rot_ccw_req = 1'b0;
    end
    idle_run(n);
    @(negedge clk);
    check("pre_reset_check", mk(1, 1, 1, 0, 0, 0, ori));
    #2 rst = 1'b1;
    #1 check("reset_in_check", mk(0, 0, 0, 0, 0, 0, 0));
    auto_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ori = 2'd0;

    // Randomized transactions against a timeline model
    for (int tr = 0; tr < 40; tr++) begin
      logic       d_ccw, coll_dec, timeout, does_commit, in_check, sel;
      logic [1:0] ori_after, exp_o;
      int         k, s, last, g;
      d_ccw       = 1'($urandom_range(0, 1));
      coll_dec    = 1'($urandom_range(0, 1));
      k           = int'($urandom_range(0, HT + 2));
      timeout     = (k >= HT);
      s           = timeout ? HT + 1 : k + ST + 2;
      last        = s + CD + 1;
      does_commit = !timeout && !coll_dec;
      ori_after   = does_commit ? (d_ccw ? ori - 2'd1 : ori + 2'd1) : ori;
      for (int r = 0; r <= last; r++) begin
        int nz;
        @(negedge clk);
        in_check = !timeout && r >= k + 2 && r <= s - 1;
        sel      = in_check || (r == s && does_commit);
        exp_o    = (r <= s) ? ori : ori_after;
        check($sformatf("rand[%0d].rel%0d", tr, r),
              mk(r >= 1, r >= 1 && r <= s, sel && !d_ccw, sel && d_ccw,
                 does_commit && r == s, !does_commit && r == s, exp_o));
        nz = int'($urandom_range(0, 7));
        if (r == 0)        drive(!d_ccw, d_ccw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else if (r < last) drive(nz == 1 || nz == 3, nz == 2 || nz == 3, 0, 1'($urandom_range(0, 1)));
        else               drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (r >= 1 && r <= k)           game_idle = 1'b0;
        else if (r > k && r < s)        game_idle = 1'b1;
        else if (r >= 1)                game_idle = 1'($urandom_range(0, 1));
        if (!timeout && r == k + ST + 1) collide = coll_dec;
      end
      ori = ori_after;
      g = int'($urandom_range(0, 3));
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        check($sformatf("rand_gap[%0d]", tr), mk(0, 0, 0, 0, 0, 0, ori));
        drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
